// File: rtl/window_gen.sv
// rtl/window_gen.sv - frame buffer that loads a raster pixel stream and emits every KxK window
// Windows leave in raster order over valid/ready, one per cycle under sustained ready.

module window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5,
    parameter int PW    = 8,
    parameter int CW    = 5
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                FRAME_START,
    input  logic [PW-1:0]       PIX_IN,
    input  logic                PIX_VALID,
    output logic                PIX_READY,
    output logic [K*K*PW-1:0]   WIN_OUT,
    output logic [CW-1:0]       WIN_X,
    output logic [CW-1:0]       WIN_Y,
    output logic                WIN_VALID,
    input  logic                WIN_READY,
    output logic                WIN_LAST,
    output logic                BUSY
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int WW   = K * K * PW;
    localparam int XMAX = IMG_W - K;
    localparam int YMAX = IMG_H - K;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            pix_ready_q, pix_ready_d;
    logic            win_valid_q, win_valid_d;
    logic            win_last_q, win_last_d;
    logic            busy_q, busy_d;
    logic [WW-1:0]   win_out_q, win_out_d;
    logic [CW-1:0]   win_x_q, win_x_d;
    logic [CW-1:0]   win_y_q, win_y_d;

    logic [PW-1:0]   fbuf_q [NPIX];

    logic            pix_acc;
    logic [CW-1:0]   nx, ny;
    logic [AW-1:0]   fetch_addr;
    logic [WW-1:0]   win_fetch;

    assign pix_acc = (state_q == S_LOAD) && PIX_VALID && pix_ready_q;

    // Coordinates of the window to present next: (0,0) when nothing is shown yet.
    always_comb begin
        nx = '0;
        ny = '0;
        if (win_valid_q) begin
            if (win_x_q == CW'(XMAX)) begin
                nx = '0;
                ny = win_y_q + 1'b1;
            end else begin
                nx = win_x_q + 1'b1;
                ny = win_y_q;
            end
        end
    end

    always_comb begin
        win_fetch  = '0;
        fetch_addr = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                fetch_addr = AW'((int'(ny) + i) * IMG_W + int'(nx) + j);
                win_fetch[WW-1-(i*K+j)*PW -: PW] = fbuf_q[fetch_addr];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pix_ready_d = pix_ready_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        busy_d      = busy_q;
        win_out_d   = win_out_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        case (state_q)
            S_IDLE: begin
                if (FRAME_START) begin
                    state_d     = S_LOAD;
                    pix_ready_d = 1'b1;
                    busy_d      = 1'b1;
                    idx_d       = '0;
                end
            end
            S_LOAD: begin
                if (pix_acc) begin
                    if (idx_q == AW'(NPIX - 1)) begin
                        pix_ready_d = 1'b0;
                        idx_d       = '0;
                        state_d     = S_EMIT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (!win_valid_q || WIN_READY) begin
                    if (win_last_q) begin
                        state_d     = S_IDLE;
                        win_valid_d = 1'b0;
                        win_last_d  = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        win_valid_d = 1'b1;
                        win_out_d   = win_fetch;
                        win_x_d     = nx;
                        win_y_d     = ny;
                        win_last_d  = (nx == CW'(XMAX)) && (ny == CW'(YMAX));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pix_ready_q <= 1'b0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            win_out_q   <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_ready_q <= pix_ready_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            busy_q      <= busy_d;
            win_out_q   <= win_out_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
        end
    end

    // Frame memory is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (nRST && pix_acc) begin
            fbuf_q[idx_q] <= PIX_IN;
        end
    end

    assign PIX_READY = pix_ready_q;
    assign WIN_OUT   = win_out_q;
    assign WIN_X     = win_x_q;
    assign WIN_Y     = win_y_q;
    assign WIN_VALID = win_valid_q;
    assign WIN_LAST  = win_last_q;
    assign BUSY      = busy_q;

endmodule
